// File: rtl/shift_arbiter_if.sv
// Handshake bundle for shift_arbiter: two requester channels, the result
// channel and the completed-result counter.
//   reqK_valid/ready/x/n/op : requester K request (K = 0, 1)
//   res_valid/ready/data/id : held result and its requester index
//   op_count                : number of results taken by the consumer
// Modport slave is the arbiter's view; modport master is the environment's.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_x;
  logic [31:0] req0_n;
  logic [1:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_x;
  logic [31:0] req1_n;
  logic [1:0]  req1_op;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;
  logic [15:0] op_count;

  modport slave (
    input  req0_valid, req0_x, req0_n, req0_op,
    input  req1_valid, req1_x, req1_n, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, op_count
  );

  modport master (
    output req0_valid, req0_x, req0_n, req0_op,
    output req1_valid, req1_x, req1_n, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, op_count
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin arbiter in front of a 32-bit
// shifter with a one-entry result register (one result per cycle when the
// consumer keeps res_ready high).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - shift_arbiter_if.slave (requests, result, op_count)
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 rotate-right when SHIFT_ROTATE_EN is
// defined, otherwise pass-through of x.
module shift_arbiter (
  input logic             clk,
  input logic             rst,
  shift_arbiter_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [DW-1:0]   data_q, data_d;
  logic            id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            can_accept;
  logic            grant1;
  logic            acc0, acc1, accept;
  logic [DW-1:0]   sel_x, sel_n;
  logic [1:0]      sel_op;
  logic [DW-1:0]   shift_res;

  // Shift amounts of 32 or more saturate: zero for logical, sign fill for SRA.
  function automatic logic [DW-1:0] do_shift(input logic [DW-1:0] x,
                                             input logic [DW-1:0] n,
                                             input logic [1:0]    op);
    logic        big;
    logic [63:0] dbl;
    big = |n[DW-1:5];
    dbl = 64'({x, x} >> n[4:0]);
    case (op)
      2'b00:   do_shift = big ? '0 : DW'(x << n[4:0]);
      2'b01:   do_shift = big ? '0 : DW'(x >> n[4:0]);
      2'b10:   do_shift = big ? {DW{x[DW-1]}} : DW'($signed(x) >>> n[4:0]);
`ifdef SHIFT_ROTATE_EN
      default: do_shift = dbl[DW-1:0];
`else
      default: do_shift = (dbl[DW-1:0] & '0) | x;
`endif
    endcase
  endfunction

  // Round-robin grant and acceptance; the slot frees when the held result leaves.
  always_comb begin
    can_accept = (state_q == IDLE) || bus.res_ready;
    if (bus.req0_valid && bus.req1_valid) grant1 = ~last_q;
    else                                  grant1 = bus.req1_valid;
    acc0   = !rst && can_accept && bus.req0_valid && !grant1;
    acc1   = !rst && can_accept && bus.req1_valid &&  grant1;
    accept = acc0 || acc1;
    sel_x  = grant1 ? bus.req1_x  : bus.req0_x;
    sel_n  = grant1 ? bus.req1_n  : bus.req0_n;
    sel_op = grant1 ? bus.req1_op : bus.req0_op;
    shift_res = do_shift(sel_x, sel_n, sel_op);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (bus.res_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load on accept, count consumed results.
  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (accept) begin
      data_d = shift_res;
      id_d   = grant1;
      last_d = grant1;
    end
    if ((state_q == HOLD) && bus.res_ready) cnt_d = cnt_q + CW'(1);
  end

  // Datapath registers; last-grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.res_valid  = (state_q == HOLD);
  assign bus.res_data   = data_q;
  assign bus.res_id     = id_q;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed scenarios plus randomized traffic,
// with expected results queued by the driver and checked by a monitor.
module tb_shift_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  shift_arbiter_if bus ();

  shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic [15:0] pops;
  logic m_hold;
  int   m_last;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference result computed directly from the operation definitions.
  function automatic logic [31:0] ref_op(input logic [31:0] x,
                                         input logic [31:0] n,
                                         input logic [1:0]  op);
    logic [31:0] r;
    case (op)
      2'b00: ref_op = x << n;
      2'b01: ref_op = x >> n;
      2'b10: ref_op = 32'($signed(x) >>> n);
      default: begin
`ifdef SHIFT_ROTATE_EN
        r = x;
        for (int i = 0; i < int'(n % 32); i++) r = {r[0], r[31:1]};
        ref_op = r;
`else
        ref_op = x;
`endif
      end
    endcase
  endfunction

  // One clock cycle of stimulus: called just after a rising edge.
  task automatic cyc(input logic v0, input logic [31:0] x0, input logic [31:0] n0,
                     input logic [1:0] o0, input logic v1, input logic [31:0] x1,
                     input logic [31:0] n1, input logic [1:0] o1,
                     input logic rr, input logic r);
    logic e0, e1, can;
    int   win;
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_n = n0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_n = n1; bus.req1_op = o1;
    bus.res_ready  = rr;
    rst            = r;
    @(negedge clk);
    can = !m_hold || rr;
    if (v0 && v1) win = (m_last == 0) ? 1 : 0;
    else          win = v1 ? 1 : 0;
    e0 = !r && can && v0 && (win == 0);
    e1 = !r && can && v1 && (win == 1);
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_hold = 1'b0;
      m_last = 1;
    end else if (e0 || e1) begin
      q.push_back({win[0], win == 1 ? ref_op(x1, n1, o1) : ref_op(x0, n0, o0)});
      m_last = win;
      m_hold = 1'b1;
    end else if (rr) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, rr, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
  endtask

  // Monitor: held result must match the queue head; pop on consumer handshake.
  always @(negedge clk) begin
    if (rst) begin
      pops = '0;
    end else begin
      chk("res_valid", 32'(bus.res_valid), 32'(q.size() != 0));
      chk("op_count", 32'(bus.op_count), 32'(pops));
      if (q.size() != 0 && bus.res_valid) begin
        chk("res_data", bus.res_data, q[0].data);
        chk("res_id", 32'(bus.res_id), 32'(q[0].id));
        if (bus.res_ready) begin
          void'(q.pop_front());
          pops = pops + 16'd1;
        end
      end
    end
  end

  function automatic logic [31:0] rnd_n();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'($urandom_range(0, 40));
  endfunction

  initial begin
    logic [31:0] rot_exp;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_n = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_n = '0; bus.req1_op = '0;
    bus.res_ready = 1'b0;
    m_hold = 1'b0;
    m_last = 1;
    do_reset();
    do_reset();

    // Reset state.
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);

    // Single SRA request.
    cyc(1'b1, 32'h8000_0000, 32'd4, 2'b10, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("single_data", bus.res_data, 32'hF800_0000);
    chk("single_id", 32'(bus.res_id), 32'd0);
    chk("single_valid", 32'(bus.res_valid), 32'd1);

    // Out-of-range shift amounts, back to back.
    cyc(1'b1, 32'h8000_00F0, 32'h40, 2'b00, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("oor_sll", bus.res_data, 32'h0000_0000);
    cyc(1'b1, 32'h8000_00F0, 32'h40, 2'b01, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("oor_srl", bus.res_data, 32'h0000_0000);
    cyc(1'b1, 32'h8000_00F0, 32'h40, 2'b10, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("oor_sra", bus.res_data, 32'hFFFF_FFFF);

    // Rotate / pass-through op.
`ifdef SHIFT_ROTATE_EN
    rot_exp = 32'h8000_0000;
`else
    rot_exp = 32'h0000_0001;
`endif
    cyc(1'b1, 32'h1, 32'h21, 2'b11, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("op11", bus.res_data, rot_exp);
    idle(1'b1);

    // Contention after reset: ids alternate starting at 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(i + 1), 32'd1, 2'b00, 1'b1, 32'(i + 100), 32'd2, 2'b01, 1'b1, 1'b0);
      chk("rr_id", 32'(bus.res_id), 32'(i % 2));
      chk("rr_valid", 32'(bus.res_valid), 32'd1);
    end
    idle(1'b1);
    chk("rr_op_count", 32'(bus.op_count), 32'd4);

    // Backpressure: req1 waits while result is held.
    cyc(1'b1, 32'hDEAD_BEEF, 32'd8, 2'b01, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, '0, '0, 2'b00, 1'b1, 32'h1234_5678, 32'd4, 2'b00, 1'b0, 1'b0);
    chk("bp_data", bus.res_data, 32'h00DE_ADBE);
    cyc(1'b0, '0, '0, 2'b00, 1'b1, 32'h1234_5678, 32'd4, 2'b00, 1'b1, 1'b0);
    chk("bp_accept", bus.res_data, 32'h2345_6780);
    chk("bp_id", 32'(bus.res_id), 32'd1);

    // Reset while holding, then contention: req0 first.
    cyc(1'b1, 32'h5, 32'd1, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.op_count), 32'd0);
    cyc(1'b1, 32'h3, 32'd0, 2'b00, 1'b1, 32'h7, 32'd0, 2'b00, 1'b1, 1'b0);
    chk("mid_rst_id", 32'(bus.res_id), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom(), rnd_n(), 2'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 6, $urandom(), rnd_n(), 2'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
